ncr5380_initiator: RTL and testbench

NCR5380_INITIATOR -- requirements
Module: ncr5380_initiator

---
 rtl/ncr5380_initiator.sv | 238 +++++++++++++++++++++++
 tb/tb_ncr5380_initiator.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ncr5380_initiator.sv
// ============================================================================
//  Module      : ncr5380_initiator
//  Description : NCR5380-style SCSI initiator: CPU register file, manual bus
//                control and a pseudo-DMA REQ/ACK handshake engine.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ncr5380_initiator #(
    parameter int ACK_HOLD = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] addr,
    input  logic       cpu_wr,
    input  logic       cpu_rd,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    input  logic       dma_wr,
    input  logic       dma_rd,
    output logic       drq,
    output logic       irq,
    output logic       scsi_sel,
    output logic       scsi_atn,
    output logic       scsi_ack,
    output logic       scsi_rst,
    output logic [7:0] scsi_dout,
    input  logic       scsi_bsy,
    input  logic       scsi_req,
    input  logic       scsi_msg,
    input  logic       scsi_cd,
    input  logic       scsi_io,
    input  logic [7:0] scsi_din
);

    localparam logic [7:0] ICR_MASK = 8'h97;
    localparam logic [3:0] ACK_LOAD = 4'(ACK_HOLD - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_REQ  = 3'd1,
        S_WAIT_CPU  = 3'd2,
        S_ACK       = 3'd3,
        S_WAIT_NREQ = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [12:0] bus_q, bus_d;
    logic        bsy_prev_q, bsy_prev_d;
    logic [7:0]  odr_q, odr_d;
    logic [7:0]  idr_q, idr_d;
    logic [7:0]  icr_q, icr_d;
    logic [7:0]  mr_q, mr_d;
    logic [2:0]  tcr_q, tcr_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        irq_q, irq_d;
    logic        end_dma_q, end_dma_d;
    logic        drq_q, drq_d;
    logic        dma_ack_q, dma_ack_d;
    logic        send_q, send_d;
    logic [3:0]  cnt_q, cnt_d;

    logic        bsy_s, req_s, msg_s, cd_s, io_s;
    logic [7:0]  din_s;
    logic        phase_match;
    logic        irq_set, end_set, flag_clr;
    logic [7:0]  bus_status, bas_status, reg_mux;

    // Every target-driven signal passes through one register before use
    assign bus_d = {scsi_bsy, scsi_req, scsi_msg, scsi_cd, scsi_io, scsi_din};
    assign {bsy_s, req_s, msg_s, cd_s, io_s, din_s} = bus_q;

    assign phase_match = ({msg_s, cd_s, io_s} == tcr_q);
    assign bus_status  = {icr_q[7], bsy_s, req_s, msg_s, cd_s, io_s, icr_q[2], 1'b0};
    assign bas_status  = {end_dma_q, drq_q, 1'b0, irq_q, phase_match, 1'b0,
                          icr_q[1], scsi_ack};

    always_comb begin
        reg_mux = 8'h00;
        case (addr)
            3'd0:    reg_mux = din_s;
            3'd1:    reg_mux = icr_q;
            3'd2:    reg_mux = mr_q;
            3'd3:    reg_mux = {5'b0, tcr_q};
            3'd4:    reg_mux = bus_status;
            3'd5:    reg_mux = bas_status;
            3'd6:    reg_mux = idr_q;
            default: reg_mux = 8'h00;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        bsy_prev_d = bsy_s;
        odr_d      = odr_q;
        idr_d      = idr_q;
        icr_d      = icr_q;
        mr_d       = mr_q;
        tcr_d      = tcr_q;
        rdata_d    = rdata_q;
        drq_d      = drq_q;
        dma_ack_d  = dma_ack_q;
        send_d     = send_q;
        cnt_d      = cnt_q;
        irq_set    = 1'b0;
        end_set    = 1'b0;
        flag_clr   = cpu_rd && (addr == 3'd7);

        if (cpu_wr) begin
            case (addr)
                3'd0:    odr_d = wdata;
                3'd1:    icr_d = wdata & ICR_MASK;
                3'd2:    mr_d  = wdata;
                3'd3:    tcr_d = wdata[2:0];
                default: ;
            endcase
        end

        if (cpu_rd) begin
            rdata_d = reg_mux;
        end else if (dma_rd) begin
            rdata_d = idr_q;
        end

        case (state_q)
            S_IDLE: begin
                if (cpu_wr && mr_q[1] && (addr == 3'd5 || addr == 3'd7)) begin
                    state_d = S_WAIT_REQ;
                    send_d  = (addr == 3'd5);
                end
            end
            S_WAIT_REQ: begin
                if (req_s) begin
                    if (phase_match) begin
                        if (!send_q) begin
                            idr_d = din_s;
                        end
                        drq_d   = 1'b1;
                        state_d = S_WAIT_CPU;
                    end else begin
                        irq_set = 1'b1;
                        end_set = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_WAIT_CPU: begin
                if ((send_q && dma_wr) || (!send_q && dma_rd)) begin
                    if (send_q) begin
                        odr_d = wdata;
                    end
                    drq_d     = 1'b0;
                    dma_ack_d = 1'b1;
                    cnt_d     = ACK_LOAD;
                    state_d   = S_ACK;
                end
            end
            S_ACK: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_WAIT_NREQ;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_WAIT_NREQ: begin
                if (!req_s) begin
                    dma_ack_d = 1'b0;
                    state_d   = S_WAIT_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Leaving DMA mode or losing BSY both abandon the transfer outright
        if (cpu_wr && (addr == 3'd2) && !wdata[1] && mr_q[1]) begin
            state_d   = S_IDLE;
            drq_d     = 1'b0;
            dma_ack_d = 1'b0;
            end_set   = 1'b1;
        end else if (bsy_prev_q && !bsy_s && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            drq_d     = 1'b0;
            dma_ack_d = 1'b0;
            irq_set   = mr_q[3];
        end

        irq_d     = irq_set ? 1'b1 : (flag_clr ? 1'b0 : irq_q);
        end_dma_d = end_set ? 1'b1 : (flag_clr ? 1'b0 : end_dma_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            bus_q      <= '0;
            bsy_prev_q <= 1'b0;
            odr_q      <= 8'h00;
            idr_q      <= 8'h00;
            icr_q      <= 8'h00;
            mr_q       <= 8'h00;
            tcr_q      <= 3'b000;
            rdata_q    <= 8'h00;
            irq_q      <= 1'b0;
            end_dma_q  <= 1'b0;
            drq_q      <= 1'b0;
            dma_ack_q  <= 1'b0;
            send_q     <= 1'b0;
            cnt_q      <= 4'd0;
        end else begin
            state_q    <= state_d;
            bus_q      <= bus_d;
            bsy_prev_q <= bsy_prev_d;
            odr_q      <= odr_d;
            idr_q      <= idr_d;
            icr_q      <= icr_d;
            mr_q       <= mr_d;
            tcr_q      <= tcr_d;
            rdata_q    <= rdata_d;
            irq_q      <= irq_d;
            end_dma_q  <= end_dma_d;
            drq_q      <= drq_d;
            dma_ack_q  <= dma_ack_d;
            send_q     <= send_d;
            cnt_q      <= cnt_d;
        end
    end

    assign rdata     = rdata_q;
    assign drq       = drq_q;
    assign irq       = irq_q;
    assign scsi_sel  = icr_q[2];
    assign scsi_atn  = icr_q[1];
    assign scsi_rst  = icr_q[7];
    assign scsi_ack  = icr_q[4] | dma_ack_q;
    assign scsi_dout = (icr_q[0] || (send_q && state_q != S_IDLE)) ? odr_q : 8'h00;

endmodule

`default_nettype wire

// File: tb/tb_ncr5380_initiator.sv
// ============================================================================
//  Module      : tb_ncr5380_initiator
//  Description : Directed bench: register vector table plus DMA sequences
//                against a small behavioural SCSI target.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ncr5380_initiator;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] addr = 3'd0;
    logic       cpu_wr = 1'b0, cpu_rd = 1'b0, dma_wr = 1'b0, dma_rd = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic [7:0] rdata;
    logic       drq, irq;
    logic       scsi_sel, scsi_atn, scsi_ack, scsi_rst;
    logic [7:0] scsi_dout;
    logic       scsi_bsy = 1'b0, scsi_req = 1'b0, scsi_msg = 1'b0;
    logic       scsi_cd = 1'b0, scsi_io = 1'b0;
    logic [7:0] scsi_din = 8'h00;

    int errors = 0;
    int checks = 0;

    ncr5380_initiator #(.ACK_HOLD(2)) dut (
        .clk(clk), .rst(rst), .addr(addr), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd),
        .wdata(wdata), .rdata(rdata), .dma_wr(dma_wr), .dma_rd(dma_rd),
        .drq(drq), .irq(irq), .scsi_sel(scsi_sel), .scsi_atn(scsi_atn),
        .scsi_ack(scsi_ack), .scsi_rst(scsi_rst), .scsi_dout(scsi_dout),
        .scsi_bsy(scsi_bsy), .scsi_req(scsi_req), .scsi_msg(scsi_msg),
        .scsi_cd(scsi_cd), .scsi_io(scsi_io), .scsi_din(scsi_din)
    );

    always #5 clk = ~clk;

    // ACK pulse monitor: counts pulses and tracks the shortest one
    logic mon_en = 1'b0;
    int   run = 0, ack_min = 255, ack_cnt = 0;
    always @(negedge clk) begin
        if (!mon_en) begin
            run = 0; ack_min = 255; ack_cnt = 0;
        end else if (scsi_ack) begin
            if (run == 0) ack_cnt++;
            run++;
        end else if (run > 0) begin
            if (run < ack_min) ack_min = run;
            run = 0;
        end
    end

    typedef struct {
        logic       wr;
        logic [2:0] a;
        logic [7:0] d;
        logic [4:0] bus;      // {bsy,req,msg,cd,io}
        logic [7:0] din;
        logic [7:0] exp_rd;
        logic [7:0] exp_dout;
        logic [3:0] exp_ctl;  // {rst,ack,sel,atn}
    } vec_t;

    vec_t       vecs[18];
    logic [7:0] src[512];
    logic [7:0] tx_got[4];

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting, expected event", name);
    endtask

    task automatic cpu_write(input logic [2:0] a, input logic [7:0] d);
        addr = a; wdata = d; cpu_wr = 1'b1;
        step();
        cpu_wr = 1'b0;
    endtask

    task automatic cpu_read(input logic [2:0] a);
        addr = a; cpu_rd = 1'b1;
        step();
        cpu_rd = 1'b0;
    endtask

    task automatic set_bus(input logic [4:0] b, input logic [7:0] d);
        {scsi_bsy, scsi_req, scsi_msg, scsi_cd, scsi_io} = b;
        scsi_din = d;
    endtask

    task automatic wait_drq(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (drq === 1'b1) begin ok = 1'b1; break; end
            step();
        end
        if (!ok) timeout("wait_drq");
    endtask

    task automatic wait_ack(input logic v, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (scsi_ack === v) begin ok = 1'b1; break; end
            step();
        end
        if (!ok) timeout("wait_ack");
    endtask

    task automatic target_rx();
        bit ok;
        for (int i = 0; i < 512; i++) begin
            scsi_din = src[i];
            scsi_req = 1'b1;
            wait_ack(1'b1, ok);
            if (!ok) break;
            scsi_req = 1'b0;
            wait_ack(1'b0, ok);
            if (!ok) break;
        end
        scsi_req = 1'b0;
    endtask

    task automatic cpu_rx(output int bad, output int got);
        bit ok;
        bad = 0; got = 0;
        for (int i = 0; i < 512; i++) begin
            wait_drq(ok);
            if (!ok) break;
            dma_rd = 1'b1;
            step();
            dma_rd = 1'b0;
            got++;
            if (rdata !== src[i]) begin
                bad++;
                if (bad == 1) $display("byte %0d: got %h expected %h", i, rdata, src[i]);
            end
        end
    endtask

    task automatic target_tx();
        bit ok;
        for (int i = 0; i < 4; i++) begin
            scsi_req = 1'b1;
            wait_ack(1'b1, ok);
            if (!ok) break;
            tx_got[i] = scsi_dout;
            scsi_req = 1'b0;
            wait_ack(1'b0, ok);
            if (!ok) break;
        end
        scsi_req = 1'b0;
    endtask

    task automatic cpu_tx();
        bit ok;
        for (int i = 0; i < 4; i++) begin
            wait_drq(ok);
            if (!ok) break;
            wdata  = 8'hA5 + 8'(i);
            dma_wr = 1'b1;
            step();
            dma_wr = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  bad, got;
        bit  ok;

        vecs[0]  = '{1'b0, 3'd1, 8'h00, 5'b00000, 8'h00, 8'h00, 8'h00, 4'h0};
        vecs[1]  = '{1'b0, 3'd4, 8'h00, 5'b00000, 8'h00, 8'h00, 8'h00, 4'h0};
        vecs[2]  = '{1'b0, 3'd5, 8'h00, 5'b00000, 8'h00, 8'h08, 8'h00, 4'h0};
        vecs[3]  = '{1'b1, 3'd0, 8'h01, 5'b00000, 8'h00, 8'h00, 8'h00, 4'h0};
        vecs[4]  = '{1'b1, 3'd1, 8'h05, 5'b00000, 8'h00, 8'h00, 8'h01, 4'h2};
        vecs[5]  = '{1'b0, 3'd4, 8'h00, 5'b10000, 8'h00, 8'h42, 8'h01, 4'h2};
        vecs[6]  = '{1'b1, 3'd1, 8'hFF, 5'b10000, 8'h00, 8'h00, 8'h01, 4'hF};
        vecs[7]  = '{1'b0, 3'd1, 8'h00, 5'b10000, 8'h00, 8'h97, 8'h01, 4'hF};
        vecs[8]  = '{1'b1, 3'd3, 8'h02, 5'b10000, 8'h00, 8'h00, 8'h01, 4'hF};
        vecs[9]  = '{1'b1, 3'd0, 8'h08, 5'b10000, 8'h00, 8'h00, 8'h08, 4'hF};
        vecs[10] = '{1'b1, 3'd1, 8'h11, 5'b10000, 8'h00, 8'h00, 8'h08, 4'h4};
        vecs[11] = '{1'b0, 3'd5, 8'h00, 5'b11010, 8'h00, 8'h09, 8'h08, 4'h4};
        vecs[12] = '{1'b0, 3'd4, 8'h00, 5'b11010, 8'h00, 8'h68, 8'h08, 4'h4};
        vecs[13] = '{1'b0, 3'd0, 8'h00, 5'b11010, 8'h5A, 8'h5A, 8'h08, 4'h4};
        vecs[14] = '{1'b0, 3'd3, 8'h00, 5'b11010, 8'h5A, 8'h02, 8'h08, 4'h4};
        vecs[15] = '{1'b0, 3'd2, 8'h00, 5'b11010, 8'h5A, 8'h00, 8'h08, 4'h4};
        vecs[16] = '{1'b1, 3'd1, 8'h00, 5'b10000, 8'h00, 8'h00, 8'h00, 4'h0};
        vecs[17] = '{1'b0, 3'd7, 8'h00, 5'b10000, 8'h00, 8'h00, 8'h00, 4'h0};
        for (int i = 0; i < 512; i++) src[i] = 8'((i * 7 + 3) & 255);

        repeat (3) step();
        rst = 1'b0;
        step();
        chk("reset_dout", scsi_dout, 8'h00);
        chk("reset_ctl", {4'h0, scsi_rst, scsi_ack, scsi_sel, scsi_atn}, 8'h00);
        chk("reset_drq_irq", {6'h0, drq, irq}, 8'h00);

        for (int i = 0; i < 18; i++) begin
            set_bus(vecs[i].bus, vecs[i].din);
            step(); step();
            if (vecs[i].wr) cpu_write(vecs[i].a, vecs[i].d);
            else begin
                cpu_read(vecs[i].a);
                chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rd);
            end
            chk($sformatf("vec%0d_dout", i), scsi_dout, vecs[i].exp_dout);
            chk($sformatf("vec%0d_ctl", i),
                {4'h0, scsi_rst, scsi_ack, scsi_sel, scsi_atn}, {4'h0, vecs[i].exp_ctl});
        end

        // 512-byte DMA receive in data-in phase
        cpu_write(3'd2, 8'h02);
        cpu_write(3'd3, 8'h01);
        set_bus(5'b10001, 8'h00);
        step(); step();
        mon_en = 1'b1;
        cpu_write(3'd7, 8'h00);
        fork
            target_rx();
            cpu_rx(bad, got);
        join
        step(); step();
        chk("rx_bytes_seen_lo", 8'(got), 8'(512));
        chk("rx_bytes_seen_hi", 8'(got >> 8), 8'(512 >> 8));
        chk("rx_mismatches", 8'(bad), 8'h00);
        chk("rx_ack_pulses_hi", 8'(ack_cnt >> 8), 8'(512 >> 8));
        checks++;
        if (ack_min < 2) begin
            errors++;
            $display("FAIL rx_ack_min_width: got %0d cycles required >= 2", ack_min);
        end
        mon_en = 1'b0;
        cpu_read(3'd5);
        chk("rx_done_status", rdata, 8'h08);

        // Stray dma_rd outside WAIT_CPU just returns IDR
        dma_rd = 1'b1;
        step();
        dma_rd = 1'b0;
        chk("stray_dma_rd", rdata, src[511]);
        step(); step();
        chk("stray_drq", {7'h0, drq}, 8'h00);

        // Clearing DMA mode mid-transfer flags end of DMA
        cpu_write(3'd2, 8'h00);
        cpu_read(3'd5);
        chk("mr_clear_end_dma", rdata, 8'h88);
        cpu_read(3'd7);
        cpu_read(3'd5);
        chk("mr_clear_flag_cleared", rdata, 8'h08);

        // 4-byte DMA send in data-out phase
        cpu_write(3'd2, 8'h02);
        cpu_write(3'd3, 8'h00);
        set_bus(5'b10000, 8'h00);
        step(); step();
        mon_en = 1'b1;
        cpu_write(3'd5, 8'h00);
        fork
            target_tx();
            cpu_tx();
        join
        step(); step();
        for (int i = 0; i < 4; i++)
            chk($sformatf("tx_byte%0d", i), tx_got[i], 8'hA5 + 8'(i));
        chk("tx_ack_pulses", 8'(ack_cnt), 8'd4);
        mon_en = 1'b0;
        cpu_write(3'd2, 8'h00);
        cpu_read(3'd7);

        // Phase change to status during a receive
        cpu_write(3'd2, 8'h02);
        cpu_write(3'd3, 8'h01);
        set_bus(5'b10001, 8'h00);
        step(); step();
        cpu_write(3'd7, 8'h00);
        step();
        set_bus(5'b11011, 8'h00);
        repeat (4) step();
        chk("phase_chg_drq", {7'h0, drq}, 8'h00);
        chk("phase_chg_irq_pin", {7'h0, irq}, 8'h01);
        cpu_read(3'd5);
        chk("phase_chg_status", rdata, 8'h90);
        cpu_read(3'd7);
        cpu_read(3'd5);
        chk("phase_chg_cleared", rdata, 8'h00);
        set_bus(5'b10001, 8'h00);
        step(); step();

        // Reset while the handshake sits in ACK
        cpu_write(3'd3, 8'h01);
        cpu_write(3'd7, 8'h00);
        set_bus(5'b11001, 8'hC3);
        wait_drq(ok);
        dma_rd = 1'b1;
        step();
        dma_rd = 1'b0;
        chk("rst_test_rdata", rdata, 8'hC3);
        chk("rst_test_ack_before", {7'h0, scsi_ack}, 8'h01);
        rst = 1'b1;
        step();
        chk("rst_mid_ack", {7'h0, scsi_ack}, 8'h00);
        chk("rst_mid_drq", {7'h0, drq}, 8'h00);
        chk("rst_mid_rdata", rdata, 8'h00);
        rst = 1'b0;
        cpu_read(3'd1); chk("rst_icr", rdata, 8'h00);
        cpu_read(3'd2); chk("rst_mr", rdata, 8'h00);
        cpu_read(3'd3); chk("rst_tcr", rdata, 8'h00);
        cpu_read(3'd6); chk("rst_idr", rdata, 8'h00);
        cpu_read(3'd5); chk("rst_status", rdata, 8'h00);
        repeat (5) step();
        chk("rst_idle_ack", {7'h0, scsi_ack}, 8'h00);
        chk("rst_idle_dout", scsi_dout, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
